apb_req_master: RTL and testbench

- Sequences one shared 8-bit APB bus on behalf of NREQ local requesters.
- Arbitrates round-robin between requesters and drives the APB SETUP/ACCESS phases (psel/pen/paddr/pwrite/pwdata).
- Waits on pready, returns prdata, then acknowledges the requester.
- Sits between internal register-access clients and the APB slave fabric that the protocol checkers monitor.

---
 rtl/apb_req_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 67 ++++++
 rtl/apb_req_master.sv | 172 +++++++++++++++++
 tb/tb_apb_req_master.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_req_pkg.sv
// ---------------------------------------------------------------------------
// apb_req_pkg
// Shared types and default sizing for the APB request master.
//   apb_state_t    : bus-sequencer state (IDLE, SETUP, ACCESS)
//   DEF_AW/DEF_DW  : default APB address / data widths
//   DEF_TO_CYCLES  : default ACCESS-phase timeout, used only when the
//                    design is built with APB_TIMEOUT_EN
// ---------------------------------------------------------------------------
package apb_req_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int DEF_AW        = 8;
    localparam int DEF_DW        = 8;
    localparam int DEF_TO_CYCLES = 16;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. Priority starts at the index just after the last
// grant and wraps modulo NREQ. The grant is combinational; the last-grant
// pointer only moves when i_en is high.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req  [NREQ]  : request vector
//   i_en           : commit strobe, loads the pointer with o_idx
//   o_gnt  [NREQ]  : one-hot grant (all zero when nothing is requested)
//   o_idx  [IW]    : index of the granted requester
//   o_vld          : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_vld
);

    logic [IW-1:0]   r_ptr;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_vld;

    // First pass covers indices above the pointer, second pass wraps
    // around to the pointer itself, giving the modulo-NREQ search order.
    always_comb begin
        w_gnt = '0;
        w_idx = '0;
        w_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_vld && (i > int'(r_ptr)) && i_req[i]) begin
                w_vld    = 1'b1;
                w_gnt[i] = 1'b1;
                w_idx    = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_vld && (i <= int'(r_ptr)) && i_req[i]) begin
                w_vld    = 1'b1;
                w_gnt[i] = 1'b1;
                w_idx    = IW'(i);
            end
        end
    end

    // Pointer resets to NREQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= IW'(NREQ - 1);
        end else if (i_en) begin
            r_ptr <= w_idx;
        end
    end

    assign o_gnt = w_gnt;
    assign o_idx = w_idx;
    assign o_vld = w_vld;

endmodule

// File: rtl/apb_req_master.sv
// ---------------------------------------------------------------------------
// apb_req_master
// Sequences one shared APB bus for NREQ local requesters: round-robin
// arbitration, SETUP/ACCESS phases, pready wait states, read-data return
// and a one-cycle ack back to the served requester. All outputs registered.
// Optional build macro: APB_TIMEOUT_EN -- bounds the ACCESS phase to
// TO_CYCLES cycles and reports expiry through err. Without it err is 0.
// Ports:
//   pclk, prst          : clock, asynchronous active-low reset
//   req/wr  [NREQ]      : per-requester request and direction (1 = write)
//   addr    [NREQ*AW]   : per-requester address, requester i at [i*AW +: AW]
//   wdata   [NREQ*DW]   : per-requester write data, same packing
//   ack     [NREQ]      : one-cycle completion pulse
//   rdata   [DW], err   : read data / error, valid with ack
//   psel, pen, pwrite, paddr, pwdata : APB master outputs
//   pready, prdata      : APB slave response
// ---------------------------------------------------------------------------
module apb_req_master
    import apb_req_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int TO_CYCLES = DEF_TO_CYCLES
) (
    input  logic               pclk,
    input  logic               prst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    wr,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic               err,
    output logic               psel,
    output logic               pen,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic               pready,
    input  logic [DW-1:0]      prdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 1) begin : g_bad_param
        $error("apb_req_master: NREQ must be 2..8 and TO_CYCLES >= 1");
    end

    apb_state_t      r_state;
    logic            r_psel;
    logic            r_pen;
    logic            r_pwrite;
    logic [AW-1:0]   r_paddr;
    logic [DW-1:0]   r_pwdata;
    logic [NREQ-1:0] r_ack;
    logic [DW-1:0]   r_rdata;
    logic [NREQ-1:0] r_gnt;

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_vld;
    logic            w_en;

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
    logic          r_err;
    logic [CW-1:0] r_cnt;
`endif

    // The requester being acked still has req high this cycle; mask it so
    // the same request is not granted twice.
    assign w_elig = req & ~r_ack;
    assign w_en   = (r_state == IDLE) && w_vld;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_clk   (pclk),
        .i_rst_n (prst),
        .i_req   (w_elig),
        .i_en    (w_en),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_vld   (w_vld)
    );

    // The APB output registers double as the request latch: they are loaded
    // at grant and held through SETUP and ACCESS.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            r_state  <= IDLE;
            r_psel   <= 1'b0;
            r_pen    <= 1'b0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_ack    <= '0;
            r_rdata  <= '0;
            r_gnt    <= '0;
`ifdef APB_TIMEOUT_EN
            r_err    <= 1'b0;
            r_cnt    <= '0;
`endif
        end else begin
            r_ack <= '0;
`ifdef APB_TIMEOUT_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_vld) begin
                        r_gnt    <= w_gnt;
                        r_psel   <= 1'b1;
                        r_pen    <= 1'b0;
                        r_pwrite <= wr[w_idx];
                        r_paddr  <= addr[int'(w_idx)*AW +: AW];
                        r_pwdata <= wr[w_idx] ? wdata[int'(w_idx)*DW +: DW] : '0;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_pen   <= 1'b1;
                    r_state <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                ACCESS: begin
                    // pready wins over an expiring count in the same cycle.
                    if (pready) begin
                        r_psel  <= 1'b0;
                        r_pen   <= 1'b0;
                        r_ack   <= r_gnt;
                        r_state <= IDLE;
                        if (!r_pwrite) begin
                            r_rdata <= prdata;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else if (r_cnt == CW'(TO_CYCLES - 1)) begin
                        r_psel  <= 1'b0;
                        r_pen   <= 1'b0;
                        r_ack   <= r_gnt;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign psel   = r_psel;
    assign pen    = r_pen;
    assign pwrite = r_pwrite;
    assign paddr  = r_paddr;
    assign pwdata = r_pwdata;
    assign ack    = r_ack;
    assign rdata  = r_rdata;
`ifdef APB_TIMEOUT_EN
    assign err    = r_err;
`else
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_apb_req_master.sv
module tb_apb_req_master;

    localparam int NREQ = 2;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int TO   = 16;

    logic               pclk = 1'b0;
    logic               prst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    wr;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic               err;
    logic               psel;
    logic               pen;
    logic               pwrite;
    logic [AW-1:0]      paddr;
    logic [DW-1:0]      pwdata;
    logic               pready = 1'b0;
    logic [DW-1:0]      prdata;

    typedef struct {
        int         idx;
        logic [7:0] addr;
        logic       wr;
        logic [7:0] pwdata;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ws = 0;
    int         acc_cnt = 0;
    logic [7:0] rd_model = 8'h00;

    always #5 pclk = ~pclk;

    apb_req_master #(
        .NREQ      (NREQ),
        .AW        (AW),
        .DW        (DW),
        .TO_CYCLES (TO)
    ) dut (
        .pclk   (pclk),
        .prst   (prst),
        .req    (req),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .ack    (ack),
        .rdata  (rdata),
        .err    (err),
        .psel   (psel),
        .pen    (pen),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .pready (pready),
        .prdata (prdata)
    );

    // Slave model: raises pready after ws wait states of the ACCESS phase.
    always @(negedge pclk) begin
        if (psel && pen) begin
            pready = (acc_cnt >= ws);
            acc_cnt = acc_cnt + 1;
        end else begin
            pready = 1'b0;
            acc_cnt = 0;
        end
    end

    task automatic wait_ack(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge pclk);
            if (ack !== '0) seen = 1'b1;
        end
    endtask

    task automatic wait_setup(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge pclk);
            if (psel === 1'b1 && pen === 1'b0) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        prst = 1'b0; req = '0; wr = '0; addr = '0; wdata = '0; prdata = '0; ws = 0;
        repeat (3) @(negedge pclk);
        n_cmp++;
        if ({psel, pen, pwrite} !== 3'b000) begin
            n_bad++; $display("FAIL rst_ctrl: got %b want 000", {psel, pen, pwrite});
        end
        n_cmp++;
        if ({paddr, pwdata} !== 16'h0000) begin
            n_bad++; $display("FAIL rst_bus: got %h want 0000", {paddr, pwdata});
        end
        n_cmp++;
        if ({ack, rdata, err} !== 11'h000) begin
            n_bad++; $display("FAIL rst_resp: got %h want 000", {ack, rdata, err});
        end
        prst = 1'b1;
        rd_model = 8'h00;
        @(negedge pclk);
        n_cmp++;
        if ({psel, pen} !== 2'b00) begin
            n_bad++; $display("FAIL rst_idle: got %b want 00", {psel, pen});
        end
    endtask

    task automatic test_write_nowait;
        exp_t e;
        ws = 0;
        addr[7:0] = 8'h10; wdata[7:0] = 8'hA5; wr[0] = 1'b1; req[0] = 1'b1;
        sb.push_back('{0, 8'h10, 1'b1, 8'hA5, rd_model, 1'b0});
        e = sb[0];
        @(negedge pclk);
        n_cmp++;
        if ({psel, pen} !== 2'b10) begin
            n_bad++; $display("FAIL wr_setup_ctrl: got %b want 10", {psel, pen});
        end
        n_cmp++;
        if ({pwrite, paddr, pwdata} !== {e.wr, e.addr, e.pwdata}) begin
            n_bad++; $display("FAIL wr_setup_bus: got %h want %h", {pwrite, paddr, pwdata}, {e.wr, e.addr, e.pwdata});
        end
        @(negedge pclk);
        n_cmp++;
        if ({psel, pen, paddr, pwdata} !== {2'b11, e.addr, e.pwdata}) begin
            n_bad++; $display("FAIL wr_access: got %h want %h", {psel, pen, paddr, pwdata}, {2'b11, e.addr, e.pwdata});
        end
        @(negedge pclk);
        n_cmp++;
        if (ack !== 2'(1 << e.idx)) begin
            n_bad++; $display("FAIL wr_ack: got %b want %b", ack, 2'(1 << e.idx));
        end
        e = sb.pop_front();
        n_cmp++;
        if ({rdata, err} !== {e.rdata, e.err}) begin
            n_bad++; $display("FAIL wr_resp: got %h want %h", {rdata, err}, {e.rdata, e.err});
        end
        req[0] = 1'b0;
        @(negedge pclk);
        n_cmp++;
        if ({ack, psel, pen} !== 4'b0000) begin
            n_bad++; $display("FAIL wr_after: got %b want 0000", {ack, psel, pen});
        end
    endtask

    task automatic test_read_wait;
        exp_t e;
        bit   seen;
        ws = 2; prdata = 8'h3C;
        addr[15:8] = 8'h20; wdata[15:8] = 8'hFF; wr[1] = 1'b0; req[1] = 1'b1;
        sb.push_back('{1, 8'h20, 1'b0, 8'h00, 8'h3C, 1'b0});
        e = sb[0];
        for (int c = 0; c < 4; c++) begin
            @(negedge pclk);
            if (c == 0) begin
                addr[15:8] = 8'h55; wdata[15:8] = 8'h66; wr[1] = 1'b1;
            end
            n_cmp++;
            if ({psel, pen, pwrite, paddr, pwdata} !== {1'b1, (c != 0), e.wr, e.addr, e.pwdata}) begin
                n_bad++; $display("FAIL rd_bus_cycle%0d: got %h want %h", c,
                                  {psel, pen, pwrite, paddr, pwdata}, {1'b1, (c != 0), e.wr, e.addr, e.pwdata});
            end
        end
        wait_ack(1, seen);
        n_cmp++;
        if (ack !== 2'(1 << e.idx)) begin
            n_bad++; $display("FAIL rd_ack: got %b want %b", ack, 2'(1 << e.idx));
        end
        e = sb.pop_front();
        n_cmp++;
        if ({rdata, err} !== {e.rdata, e.err}) begin
            n_bad++; $display("FAIL rd_resp: got %h want %h", {rdata, err}, {e.rdata, e.err});
        end
        req[1] = 1'b0; wr[1] = 1'b0;
        rd_model = 8'h3C;
        @(negedge pclk);
    endtask

    task automatic test_contention;
        exp_t e;
        int   acks;
        int   last;
        prst = 1'b0; req = '0;
        @(negedge pclk);
        prst = 1'b1; rd_model = 8'h00; ws = 0;
        addr = {8'h41, 8'h40}; wdata = {8'h22, 8'h11}; wr = 2'b11;
        for (int k = 0; k < 4; k++)
            sb.push_back('{k % 2, (k % 2) ? 8'h41 : 8'h40, 1'b1, (k % 2) ? 8'h22 : 8'h11, 8'h00, 1'b0});
        req = 2'b11;
        acks = 0; last = -1;
        for (int c = 0; c < 40 && acks < 4; c++) begin
            @(negedge pclk);
            if (psel === 1'b1 && pen === 1'b0 && sb.size() > 0) begin
                n_cmp++;
                if ({paddr, pwdata} !== {sb[0].addr, sb[0].pwdata}) begin
                    n_bad++; $display("FAIL cont_setup: got %h want %h", {paddr, pwdata}, {sb[0].addr, sb[0].pwdata});
                end
            end
            if (ack !== '0) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if ({ack, rdata, err} !== {2'(1 << e.idx), e.rdata, e.err}) begin
                        n_bad++; $display("FAIL cont_ack: got %h want %h", {ack, rdata, err}, {2'(1 << e.idx), e.rdata, e.err});
                    end
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (c - last != 3) begin
                        n_bad++; $display("FAIL cont_spacing: got %0d want 3", c - last);
                    end
                end
                last = c;
                acks++;
                if (acks == 4) req = '0;
            end
        end
        n_cmp++;
        if (acks != 4) begin
            n_bad++; $display("FAIL cont_done: got %0d acks want 4", acks);
        end
        req = '0;
        sb.delete();
        @(negedge pclk);
    endtask

    task automatic test_ack_mask;
        exp_t e;
        bit   seen;
        ws = 0;
        addr[7:0] = 8'h60; wdata[7:0] = 8'h5A; wr[0] = 1'b1; req[0] = 1'b1;
        sb.push_back('{0, 8'h60, 1'b1, 8'h5A, rd_model, 1'b0});
        sb.push_back('{0, 8'h60, 1'b1, 8'h5A, rd_model, 1'b0});
        wait_ack(10, seen);
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL mask_ack1: got no ack want ack within 10 cycles");
        end
        e = sb.pop_front();
        n_cmp++;
        if (ack !== 2'(1 << e.idx)) begin
            n_bad++; $display("FAIL mask_ack1_vec: got %b want %b", ack, 2'(1 << e.idx));
        end
        @(negedge pclk);
        n_cmp++;
        if ({psel, pen, ack} !== 4'b0000) begin
            n_bad++; $display("FAIL mask_no_regrant: got %b want 0000", {psel, pen, ack});
        end
        @(negedge pclk);
        n_cmp++;
        if ({psel, pen, paddr} !== {2'b10, e.addr}) begin
            n_bad++; $display("FAIL mask_next_setup: got %h want %h", {psel, pen, paddr}, {2'b10, e.addr});
        end
        wait_ack(10, seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || ack !== 2'(1 << e.idx)) begin
            n_bad++; $display("FAIL mask_ack2: got %b want %b", ack, 2'(1 << e.idx));
        end
        req[0] = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_reset_mid;
        exp_t e;
        bit   seen;
        ws = 1000; prdata = 8'h99;
        addr[15:8] = 8'h70; wr[1] = 1'b0; req[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge pclk);
            if (pen === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL rmid_access: got pen=%b want 1", pen);
        end
        repeat (2) @(negedge pclk);
        prst = 1'b0;
        #1;
        n_cmp++;
        if ({psel, pen, ack} !== 4'b0000) begin
            n_bad++; $display("FAIL rmid_async_drop: got %b want 0000", {psel, pen, ack});
        end
        n_cmp++;
        if ({paddr, pwdata, rdata, err} !== 25'h0) begin
            n_bad++; $display("FAIL rmid_async_clr: got %h want 0", {paddr, pwdata, rdata, err});
        end
        req = 2'b11; addr[7:0] = 8'h80; wr = 2'b00; prdata = 8'h4D; ws = 0;
        @(negedge pclk);
        prst = 1'b1;
        rd_model = 8'h4D;
        sb.push_back('{0, 8'h80, 1'b0, 8'h00, 8'h4D, 1'b0});
        wait_setup(5, seen);
        n_cmp++;
        if (!seen || paddr !== sb[0].addr) begin
            n_bad++; $display("FAIL rmid_first_winner: got %h want %h", paddr, sb[0].addr);
        end
        wait_ack(5, seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || {ack, rdata, err} !== {2'(1 << e.idx), e.rdata, e.err}) begin
            n_bad++; $display("FAIL rmid_ack: got %h want %h", {ack, rdata, err}, {2'(1 << e.idx), e.rdata, e.err});
        end
        req = '0;
        @(negedge pclk);
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout;
        exp_t e;
        bit   seen;
        int   n_acc;
        for (int pass = 0; pass < 2; pass++) begin
            ws = (pass == 0) ? 1000 : TO - 1;
            prdata = 8'h77;
            addr[7:0] = 8'h30; wr[0] = 1'b0; req[0] = 1'b1;
            sb.push_back('{0, 8'h30, 1'b0, 8'h00, (pass == 0) ? 8'h00 : 8'h77, (pass == 0)});
            n_acc = 0; seen = 1'b0;
            for (int c = 0; c < 60 && !seen; c++) begin
                @(negedge pclk);
                if (pen === 1'b1) n_acc++;
                if (ack !== '0) seen = 1'b1;
            end
            n_cmp++;
            if (!seen || n_acc != TO) begin
                n_bad++; $display("FAIL to_len_pass%0d: got %0d access cycles want %0d", pass, n_acc, TO);
            end
            e = sb.pop_front();
            n_cmp++;
            if ({ack, rdata, err} !== {2'(1 << e.idx), e.rdata, e.err}) begin
                n_bad++; $display("FAIL to_resp_pass%0d: got %h want %h", pass, {ack, rdata, err}, {2'(1 << e.idx), e.rdata, e.err});
            end
            req = '0;
            @(negedge pclk);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_nowait();
        test_read_wait();
        test_contention();
        test_ack_mask();
        test_reset_mid();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
